// File: rtl/network_sequencer_if.sv
// network_sequencer_if
// Handshake bundle between the network sequencer, its upstream sample source
// and its downstream result consumer.
//
// Parameters:
//   INPUT_SIZE   number of values per input sample
//   OUTPUT_SIZE  number of values per inference result
//
// Signals:
//   in_valid   upstream sample available
//   in_ready   sequencer can accept a sample
//   in_data    sample values
//   out_valid  result held on out_data
//   out_ready  downstream accepts result
//   out_data   latched inference result
//
// Modports:
//   master  the side that supplies samples and consumes results
//   slave   the sequencer itself
interface network_sequencer_if #(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 1
);
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data [0:INPUT_SIZE-1];
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data [0:OUTPUT_SIZE-1];

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/network_sequencer.sv
// network_sequencer
// Drives one stochastic-network inference per accepted sample: latches the
// sample onto the network inputs, waits for the generator/layer pipeline to
// fill, flushes the integrators, lets the bitstream run for STREAM_LEN
// cycles, captures the integrators and finally presents the network output
// until the downstream side takes it.
//
// Parameters:
//   INPUT_SIZE   values per input sample
//   OUTPUT_SIZE  values per inference result
//   STREAM_LEN   bitstream cycles integrated per inference (1..65535)
//   SETTLE_LEN   pipeline fill cycles before the flush (1..255)
//
// Ports:
//   clk           rising-edge clock
//   n_rst         asynchronous active-low reset
//   bus           sample/result handshakes (network_sequencer_if.slave)
//   net_input     registered sample values driven to the network
//   compute       integrator flush/capture strobe to the network
//   net_output    network result values
//   busy          high whenever the sequencer is not idle
//   sample_count  completed inferences
//
// Optional feature:
//   NETWORK_SEQUENCER_COUNT_EN  when defined, sample_count counts result
//                               handshakes (wrapping at 2^32); otherwise it
//                               is tied to zero and no counter exists.
module network_sequencer #(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 1,
  parameter int STREAM_LEN  = 256,
  parameter int SETTLE_LEN  = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  network_sequencer_if.slave bus,
  output logic signed [31:0] net_input [0:INPUT_SIZE-1],
  output logic               compute,
  input  logic signed [31:0] net_output [0:OUTPUT_SIZE-1],
  output logic               busy,
  output logic [31:0]        sample_count
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FLUSH,
    RUN,
    CAPTURE,
    WAIT,
    DONE
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_LEN - 1);
  localparam logic [15:0] STREAM_LAST = 16'(STREAM_LEN - 1);

  state_t      state;
  logic [15:0] cycle_cnt;

  // Sequencer FSM. All outputs are registered and updated on the transition
  // into the state they belong to, so compute is a clean flop output with one
  // high cycle in FLUSH and one in CAPTURE. The cycle counter restarts from
  // zero on every state entry; it only advances in the timed states and
  // leaves them at LEN-1, so it can never wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      cycle_cnt     <= '0;
      compute       <= 1'b0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      net_input     <= '{default: '0};
      bus.out_data  <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          cycle_cnt <= '0;
          if (bus.in_valid) begin
            net_input    <= bus.in_data;
            busy         <= 1'b1;
            bus.in_ready <= 1'b0;
            state        <= SETTLE;
          end
        end
        SETTLE: begin
          if (cycle_cnt == SETTLE_LAST) begin
            cycle_cnt <= '0;
            compute   <= 1'b1;
            state     <= FLUSH;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        // The flush strobe throws away whatever the integrators collected
        // while the pipeline was still filling with the previous sample.
        FLUSH: begin
          cycle_cnt <= '0;
          compute   <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (cycle_cnt == STREAM_LAST) begin
            cycle_cnt <= '0;
            compute   <= 1'b1;
            state     <= CAPTURE;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        CAPTURE: begin
          cycle_cnt <= '0;
          compute   <= 1'b0;
          state     <= WAIT;
        end
        // One extra cycle lets the network's output register reflect the
        // capture before we sample it.
        WAIT: begin
          cycle_cnt     <= '0;
          bus.out_data  <= net_output;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          cycle_cnt <= '0;
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          cycle_cnt     <= '0;
          compute       <= 1'b0;
          busy          <= 1'b0;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef NETWORK_SEQUENCER_COUNT_EN
  logic [31:0] count_q;

  // Counts result handshakes; out_valid is high exactly when in DONE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (state == DONE && bus.out_ready) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign sample_count = count_q;
`else
  assign sample_count = '0;
`endif

endmodule

// File: tb/tb_network_sequencer.sv
// tb_network_sequencer
// Bench for network_sequencer. A main instance (SETTLE_LEN=2, STREAM_LEN=8)
// is followed every cycle by a timing model that predicts the outputs from
// the handshake edge alone; a second instance (SETTLE_LEN=1, STREAM_LEN=1)
// covers the shortest schedule with literal expectations.
// Honours NETWORK_SEQUENCER_COUNT_EN for the expected sample_count.
module tb_network_sequencer;

  localparam int IN_N  = 2;
  localparam int OUT_N = 1;
  localparam int S     = 2;
  localparam int L     = 8;
  // offset from the accepting edge to the first out_valid period
  localparam int DV    = S + L + 3;

`ifdef NETWORK_SEQUENCER_COUNT_EN
  localparam int COUNT_ON = 1;
`else
  localparam int COUNT_ON = 0;
`endif

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  network_sequencer_if #(.INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N)) bus ();
  network_sequencer_if #(.INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N)) bus_min ();

  logic signed [31:0] net_input      [0:IN_N-1];
  logic signed [31:0] net_output     [0:OUT_N-1];
  logic               compute;
  logic               busy;
  logic [31:0]        sample_count;

  logic signed [31:0] net_input_min  [0:IN_N-1];
  logic signed [31:0] net_output_min [0:OUT_N-1];
  logic               compute_min;
  logic               busy_min;
  logic [31:0]        sample_count_min;

  network_sequencer #(
    .INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N), .STREAM_LEN(L), .SETTLE_LEN(S)
  ) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus),
    .net_input(net_input), .compute(compute), .net_output(net_output),
    .busy(busy), .sample_count(sample_count)
  );

  network_sequencer #(
    .INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N), .STREAM_LEN(1), .SETTLE_LEN(1)
  ) dut_min (
    .clk(clk), .n_rst(n_rst), .bus(bus_min),
    .net_input(net_input_min), .compute(compute_min), .net_output(net_output_min),
    .busy(busy_min), .sample_count(sample_count_min)
  );

  int checks = 0;
  int errors = 0;
  int e      = 0;
  int off    = 0;

  bit                 m_active;
  int                 m_h;
  logic signed [31:0] m_net_in [0:IN_N-1];
  logic signed [31:0] m_out    [0:OUT_N-1];
  int unsigned        m_count;

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int d0, input int d1, input bit valid, input bit rdy);
    bus.in_data   = '{d0, d1};
    bus.in_valid  = valid;
    bus.out_ready = rdy;
  endtask

  // Model: remembers the accepting edge and the sample, latches the network
  // output seen just before the first out_valid period, and retires the
  // inference on the first out_ready edge after out_valid has been shown.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_active = 1'b0;
      m_h      = 0;
      m_net_in = '{default: 0};
      m_out    = '{default: 0};
      m_count  = 0;
    end else begin
      e = e + 1;
      if (!m_active) begin
        if (bus.in_valid) begin
          m_active = 1'b1;
          m_h      = e;
          m_net_in = bus.in_data;
        end
      end else begin
        if (e == m_h + DV) m_out = net_output;
        if (e > m_h + DV && bus.out_ready) begin
          m_active = 1'b0;
          m_count++;
        end
      end
    end
  end

  // Network output stand-in: one value up to the capture, another after it,
  // shifted per test so each inference carries a distinct result.
  always @(negedge clk) begin
    for (int i = 0; i < OUT_N; i++)
      net_output[i] = (m_active && e >= m_h + DV) ? 32'(99 + off + i) : 32'(57 + off + i);
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (n_rst) begin
      checkOutput("model_in_ready", bus.in_ready, !m_active);
      checkOutput("model_busy", busy, m_active);
      checkOutput("model_compute", compute,
                  m_active && (e == m_h + S || e == m_h + S + L + 1));
      checkOutput("model_out_valid", bus.out_valid, m_active && e >= m_h + DV);
      for (int i = 0; i < IN_N; i++)
        checkOutput("model_net_input", net_input[i], m_net_in[i]);
      for (int i = 0; i < OUT_N; i++)
        checkOutput("model_out_data", bus.out_data[i], m_out[i]);
      checkOutput("model_sample_count", sample_count, COUNT_ON ? m_count : 0);
    end
  end

  initial begin
    int h;
    $display("[TB] network_sequencer bench start");
    applyStimulus(0, 0, 1'b0, 1'b0);
    bus_min.in_valid  = 1'b0;
    bus_min.in_data   = '{default: 0};
    bus_min.out_ready = 1'b0;
    net_output_min[0] = 32'sd12345;

    // reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_compute", compute, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_net_input0", net_input[0], 0);
    checkOutput("rst_out_data", bus.out_data[0], 0);
    #2 n_rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_sample_count", sample_count, 0);

    // schedule and result latch, result held under back-pressure
    applyStimulus(100, 200, 1'b1, 1'b0);
    h = e + 1;
    @(negedge clk);
    applyStimulus(0, 0, 1'b0, 1'b0);
    for (int j = 0; j <= 22; j++) begin
      if (j == 0) begin
        checkOutput("t1_net_input0", net_input[0], 100);
        checkOutput("t1_net_input1", net_input[1], 200);
      end
      checkOutput("t1_compute", compute, (j == 2 || j == 11));
      checkOutput("t1_out_valid", bus.out_valid, (j >= 13));
      if (j >= 13) checkOutput("t1_out_data", bus.out_data[0], 57);
      if (j < 22) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t1_idle_in_ready", bus.in_ready, 1);
    checkOutput("t1_idle_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // in_valid held high across a run; data changes must not leak in
    off = 100;
    applyStimulus(11, 22, 1'b1, 1'b1);
    h = e + 1;
    while (e < h + 1) @(negedge clk);
    applyStimulus(33, 44, 1'b1, 1'b1);
    while (e < h + S + 4) @(negedge clk);
    checkOutput("bp_run_net_input0", net_input[0], 11);
    while (e < h + DV + 1) @(negedge clk);
    checkOutput("bp_idle_in_ready", bus.in_ready, 1);
    checkOutput("bp_idle_busy", busy, 0);
    @(negedge clk);
    checkOutput("bp_second_busy", busy, 1);
    checkOutput("bp_second_in_ready", bus.in_ready, 0);
    checkOutput("bp_second_net_input0", net_input[0], 33);
    checkOutput("bp_second_net_input1", net_input[1], 44);
    applyStimulus(0, 0, 1'b0, 1'b1);
    h = h + DV + 2;
    while (e < h + DV + 1) @(negedge clk);
    checkOutput("cnt_three", sample_count, COUNT_ON ? 3 : 0);
    checkOutput("cnt_last_out_data", bus.out_data[0], 157);
    applyStimulus(0, 0, 1'b0, 1'b0);

    // asynchronous reset in the middle of RUN
    off = 200;
    applyStimulus(5, 6, 1'b1, 1'b0);
    h = e + 1;
    @(negedge clk);
    applyStimulus(0, 0, 1'b0, 1'b0);
    while (e < h + S + 4) @(negedge clk);
    checkOutput("rr_busy_before", busy, 1);
    #1 n_rst = 1'b0;
    #1;
    checkOutput("rr_compute", compute, 0);
    checkOutput("rr_out_valid", bus.out_valid, 0);
    checkOutput("rr_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    checkOutput("rr_in_ready", bus.in_ready, 1);
    checkOutput("rr_sample_count", sample_count, 0);
    checkOutput("rr_out_data", bus.out_data[0], 0);
    checkOutput("rr_net_input0", net_input[0], 0);

    // normal inference after the abort, negative input value
    off = 300;
    applyStimulus(-7, 42, 1'b1, 1'b1);
    h = e + 1;
    @(negedge clk);
    applyStimulus(0, 0, 1'b0, 1'b1);
    while (e < h + DV) @(negedge clk);
    checkOutput("t4_out_valid", bus.out_valid, 1);
    checkOutput("t4_out_data", bus.out_data[0], 357);
    checkOutput("t4_net_input0", net_input[0], -7);
    @(negedge clk);
    checkOutput("t4_done_in_ready", bus.in_ready, 1);
    applyStimulus(0, 0, 1'b0, 1'b0);

    // shortest schedule on the second instance
    bus_min.in_data  = '{3, 4};
    bus_min.in_valid = 1'b1;
    @(negedge clk);
    bus_min.in_valid = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      if (j == 0) checkOutput("min_net_input0", net_input_min[0], 3);
      checkOutput("min_busy", busy_min, 1);
      checkOutput("min_compute", compute_min, (j == 1 || j == 3));
      checkOutput("min_out_valid", bus_min.out_valid, (j >= 5));
      if (j == 5) checkOutput("min_out_data", bus_min.out_data[0], 12345);
      if (j < 6) @(negedge clk);
    end
    bus_min.out_ready = 1'b1;
    @(negedge clk);
    bus_min.out_ready = 1'b0;
    checkOutput("min_idle_in_ready", bus_min.in_ready, 1);
    checkOutput("min_idle_busy", busy_min, 0);
    checkOutput("min_sample_count", sample_count_min, COUNT_ON ? 1 : 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
